// File: rtl/paddle_pulse_gen.sv
// Paddle emulator for one player: holds a paddle position and, once per frame, emits a
// pot-style pulse that rises after "position" HSYNC rises following each VSYNC rise.
module paddle_pulse_gen #(
  parameter int POS_W     = 9,
  parameter int POS_MAX   = 255,
  parameter int POS_INIT  = 128,
  parameter int STEP_SLOW = 5,
  parameter int STEP_FAST = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             hs,
  input  logic             vs,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             fast,
  input  logic             analog_en,
  input  logic [7:0]       analog_y,
  output logic [POS_W-1:0] pos,
  output logic             pulse_out,
  output logic             frame_stb
);

  typedef enum logic [1:0] {IDLE, COUNT, FIRED} state_t;

  localparam logic [POS_W:0] MAX_W  = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0] SLOW_W = (POS_W+1)'(STEP_SLOW);
  localparam logic [POS_W:0] FAST_W = (POS_W+1)'(STEP_FAST);

  state_t           state, state_nx;
  logic [POS_W-1:0] counter, counter_nx, pos_nx;
  logic             pulse_nx;
  logic             hs_r, hs_p, vs_r, vs_p;
  logic             hs_rise, vs_rise;
  logic [POS_W:0]   step, sum, a_val;

  assign hs_rise = hs_r & ~hs_p;
  assign vs_rise = vs_r & ~vs_p;

  // Position math runs one bit wider so the clamp sees overflow instead of a wrap.
  assign step  = fast ? FAST_W : SLOW_W;
  assign sum   = {1'b0, pos} + step;
  assign a_val = (POS_W+1)'(analog_y ^ 8'h80);

  always_comb begin
    pos_nx = pos;
    if (vs_rise) begin
      if (analog_en)
        pos_nx = (a_val > MAX_W) ? MAX_W[POS_W-1:0] : a_val[POS_W-1:0];
      else if (btn_up)
        pos_nx = ({1'b0, pos} < step) ? '0 : pos - step[POS_W-1:0];
      else if (btn_down)
        pos_nx = (sum > MAX_W) ? MAX_W[POS_W-1:0] : sum[POS_W-1:0];
    end
  end

  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          state_nx   = COUNT;
          counter_nx = pos;
        end
      end
      COUNT: begin
        // A frame start always restarts the count, even mid-charge.
        if (vs_rise)             counter_nx = pos;
        else if (counter == '0)  state_nx   = FIRED;
        else if (hs_rise)        counter_nx = counter - 1'b1;
      end
      FIRED: begin
        if (vs_rise) begin
          state_nx   = COUNT;
          counter_nx = pos;
        end
      end
      default: state_nx = IDLE;
    endcase
    pulse_nx = (state == FIRED) || ((state == COUNT) && (counter == '0));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      pos       <= POS_W'(POS_INIT);
      pulse_out <= 1'b0;
      frame_stb <= 1'b0;
      hs_r      <= 1'b0;
      hs_p      <= 1'b0;
      vs_r      <= 1'b0;
      vs_p      <= 1'b0;
    end else begin
      state     <= state_nx;
      counter   <= counter_nx;
      pos       <= pos_nx;
      pulse_out <= pulse_nx;
      frame_stb <= vs_rise;
      hs_r      <= hs;
      hs_p      <= hs_r;
      vs_r      <= vs;
      vs_p      <= vs_r;
    end
  end

endmodule

// File: tb/tb_paddle_pulse_gen.sv
// Directed bench for paddle_pulse_gen: table of per-frame input/expected-position records
// plus hand sequences for the count, simultaneous-edge and mid-count reset cases.
module tb_paddle_pulse_gen;

  logic       clk_sys = 1'b0;
  logic       reset, hs, vs, btn_up, btn_down, fast, analog_en;
  logic [7:0] analog_y;
  logic [8:0] pos;
  logic       pulse_out, frame_stb;

  int checks   = 0;
  int failures = 0;

  paddle_pulse_gen dut (
    .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs),
    .btn_up(btn_up), .btn_down(btn_down), .fast(fast),
    .analog_en(analog_en), .analog_y(analog_y),
    .pos(pos), .pulse_out(pulse_out), .frame_stb(frame_stb)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit         aen;
    logic [7:0] ay;
    bit         up;
    bit         dn;
    bit         fst;
    int         exp_pos;
  } vec_t;

  vec_t tbl[13];
  int   mpos;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic hs_pulse();
    hs = 1'b1; tick();
    hs = 1'b0; tick();
  endtask

  // One VSYNC: new position and strobe visible two cycles after vs goes high,
  // pulse state for the reloaded count one cycle later.
  task automatic do_frame(input string nm, input int exp_pos, input bit exp_pulse);
    vs = 1'b1; tick(); tick();
    check({nm, "_pos"}, 32'(pos), 32'(exp_pos));
    check({nm, "_stb"}, 32'(frame_stb), 32'd1);
    vs = 1'b0; tick();
    check({nm, "_stb_low"}, 32'(frame_stb), 32'd0);
    check({nm, "_pulse"}, 32'(pulse_out), 32'(exp_pulse));
  endtask

  initial begin
    tbl[0]  = '{0, 8'h00, 0, 1, 1, 8};
    tbl[1]  = '{0, 8'h00, 0, 1, 0, 13};
    tbl[2]  = '{0, 8'h00, 1, 1, 0, 8};
    tbl[3]  = '{0, 8'h00, 0, 0, 1, 8};
    tbl[4]  = '{1, 8'h80, 0, 0, 0, 0};
    tbl[5]  = '{1, 8'h00, 0, 0, 0, 128};
    tbl[6]  = '{1, 8'h7F, 0, 0, 0, 255};
    tbl[7]  = '{1, 8'h80, 0, 0, 0, 0};
    tbl[8]  = '{1, 8'h10, 1, 0, 0, 144};
    tbl[9]  = '{1, 8'h7A, 0, 0, 0, 250};
    tbl[10] = '{0, 8'h00, 0, 1, 1, 255};
    tbl[11] = '{0, 8'h00, 0, 1, 1, 255};
    tbl[12] = '{0, 8'h00, 1, 0, 1, 247};

    reset = 1'b1; hs = 0; vs = 0; btn_up = 0; btn_down = 0; fast = 0;
    analog_en = 0; analog_y = 8'h00;
    tick(); tick();
    check("rst_pos", 32'(pos), 32'd128);
    check("rst_pulse", 32'(pulse_out), 32'd0);
    check("rst_stb", 32'(frame_stb), 32'd0);
    reset = 1'b0; tick();

    // 1: full 128-line count
    do_frame("t1", 128, 0);
    for (int i = 0; i < 127; i++) hs_pulse();
    check("t1_before_last", 32'(pulse_out), 32'd0);
    hs_pulse();
    check("t1_at_last", 32'(pulse_out), 32'd0);
    tick();
    check("t1_fired", 32'(pulse_out), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("t1_stays", 32'(pulse_out), 32'd1);

    // 2: slow up steps down to the zero clamp
    btn_up = 1'b1; mpos = 128;
    for (int i = 0; i < 30; i++) begin
      int prev;
      prev = mpos;
      mpos = (mpos < 5) ? 0 : mpos - 5;
      do_frame("t2_up", mpos, prev == 0);
    end
    btn_up = 1'b0;

    // 3/4: table of button and analog frames
    for (int i = 0; i < 13; i++) begin
      int prev;
      prev      = mpos;
      analog_en = tbl[i].aen;
      analog_y  = tbl[i].ay;
      btn_up    = tbl[i].up;
      btn_down  = tbl[i].dn;
      fast      = tbl[i].fst;
      mpos      = tbl[i].exp_pos;
      do_frame($sformatf("vec%0d", i), mpos, prev == 0);
    end
    btn_up = 0; btn_down = 0; fast = 0;

    // 5: vs and hs rise together; reload wins over decrement
    analog_en = 1'b1; analog_y = 8'h8A;
    do_frame("t5_a", 10, 0);
    do_frame("t5_b", 10, 0);
    check("t5_cnt_pre", 32'(dut.counter), 32'd10);
    vs = 1'b1; hs = 1'b1; tick(); tick();
    check("t5_cnt", 32'(dut.counter), 32'd10);
    check("t5_stb", 32'(frame_stb), 32'd1);
    vs = 1'b0; hs = 1'b0; tick();
    check("t5_stb_low", 32'(frame_stb), 32'd0);
    check("t5_cnt_hold", 32'(dut.counter), 32'd10);

    // 6: reset in the middle of a count
    analog_y = 8'hA8;
    do_frame("t6_a", 40, 0);
    do_frame("t6_b", 40, 0);
    check("t6_cnt", 32'(dut.counter), 32'd40);
    reset = 1'b1; analog_en = 1'b0; tick();
    check("t6_rst_pos", 32'(pos), 32'd128);
    check("t6_rst_pulse", 32'(pulse_out), 32'd0);
    check("t6_rst_stb", 32'(frame_stb), 32'd0);
    reset = 1'b0; tick();
    for (int i = 0; i < 50; i++) begin
      hs_pulse();
      check("t6_no_pulse", 32'(pulse_out), 32'd0);
    end
    btn_up = 1'b1; btn_down = 1'b1; fast = 1'b0;
    do_frame("t6_updown", 123, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
